dl_crc32: RTL and testbench
===========================

# dl_crc32

Streaming CRC-32 accumulator (IEEE 802.3, reflected, poly 0x04C11DB7) with framed valid/ready input and held-result valid/ready output. It is a design-library sequential primitive built around the bitwise XOR reduction. It consumes a byte stream upstream of checksum compare logic and produces one CRC per frame.

## Interface
- DATA_W, 8: input beat width; legal values 8, 16, 32.
- INIT, 32'hFFFF_FFFF: CRC register value at frame start.
- XOROUT, 32'hFFFF_FFFF: XORed onto the final register to form out_crc.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  DATA_W  beat data; byte 0 = bits [7:0], processed first.
- in_last  input  1  final beat of the frame; qualified by in_valid.
- out_valid  output  1  out_crc holds a finished frame CRC.
- out_ready  input  1  consumer accepts out_crc.
- out_crc  output  32  final CRC of the last completed frame.

## Operation
- Two states: ST_ACCUM and ST_RESULT. Reset enters ST_ACCUM with crc_q = INIT.
- ST_ACCUM: in_ready = 1, out_valid = 0. On accept (in_valid & in_ready), crc_q <= step(crc_q, in_data). DATA_W/8 bytes are applied in order byte 0 first, each LSB-first (reflected).
- Accept with in_last = 1: out_crc <= step(crc_q, in_data) ^ XOROUT, crc_q <= INIT, state -> ST_RESULT.
- ST_RESULT: in_ready = 0, out_valid = 1, out_crc stable. On out_ready, state -> ST_ACCUM.
- A beat presented while in ST_RESULT is not accepted. The producer must hold it, per standard valid/ready rules.
- A frame is at least one beat. Empty frames do not exist.
- Reset values: in_ready = 1 (after the reset cycle), out_valid = 0, out_crc = 0, crc_q = INIT.
- rst_n low mid-frame or in ST_RESULT: the partial CRC and any pending result are discarded, and the block returns to ST_ACCUM / INIT on the next edge.
- Input and output signals are never combinationally connected. in_ready depends only on state.

## Timing
- One beat per cycle sustained within a frame.
- Latency: last beat accepted at edge N, then out_valid = 1 and out_crc valid from edge N through the edge where out_ready is sampled high.
- If out_ready is already high, ST_RESULT lasts exactly one cycle. The first beat of the next frame can be accepted at edge N+2, giving a minimum inter-frame gap of one cycle.
- out_valid never drops without out_ready. out_crc never changes while out_valid = 1.

## Configuration
- DL_CRC32_BYTE_COUNT_EN defined:
  - Adds output port out_len (16 bits) = number of bytes in the completed frame.
  - out_len is valid with out_valid, resets to 0, and saturates at 16'hFFFF.
  - The counter clears at frame start.
- Not defined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Package dl_crc_pkg holds:
  - state enum (ST_ACCUM, ST_RESULT);
  - CRC32_POLY_REFL = 32'hEDB8_8320;
  - CRC32_INIT and CRC32_XOROUT defaults;
  - CRC32_CHECK = 32'hCBF4_3926.
- Sub-module dl_crc32_byte: combinational single-byte update (crc_in, byte_in -> crc_out), implemented as 8 unrolled shift/XOR steps. The top level chains DATA_W/8 instances.

## Test plan
- DATA_W=8, frame "123456789" (0x31..0x39, last on 0x39), out_ready=1 -> out_crc = 0xCBF43926 one cycle after the last beat; out_len = 9 when the macro is defined.
- DATA_W=8, single beat 0x61 ("a") with last -> out_crc = 0xE8B7BE43. Single beat 0x00 -> 0xD202EF8D.
- DATA_W=32, beats 0x34333231, 0x38373635, then 0x00000039 with last on a partial-word frame is illegal. Instead use beats 0x64636261 with last ("abcd") -> out_crc = 0xED82CD11.
- Backpressure: hold out_ready=0 for 5 cycles after the result -> out_valid and out_crc stable, and in_ready = 0 with an offered beat not consumed. Raise out_ready -> the next frame "a" gives 0xE8B7BE43, with no state carried over.
- rst_n low for one cycle mid-way through "12345", then send "123456789" -> 0xCBF43926. out_valid = 0 and out_crc = 0 immediately after reset.
- Random in_valid gaps inside "123456789" -> same 0xCBF43926. in_last with in_valid=0 is ignored.

Source files
------------

// File: rtl/dl_crc_pkg.sv
// dl_crc_pkg
// Shared definitions for the dl_crc32 streaming CRC-32 accumulator:
// the FSM state type and the reflected IEEE 802.3 CRC-32 constants.
// No ports (package).

package dl_crc_pkg;

    // Frame accumulation versus holding a finished result for the consumer.
    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_RESULT = 1'b1
    } crc_state_e;

    // Bit-reversed form of 0x04C11DB7, used because data is shifted LSB-first.
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT    = 32'hFFFF_FFFF;

    // Residue-free check value of the ASCII string "123456789".
    localparam logic [31:0] CRC32_CHECK     = 32'hCBF4_3926;

endpackage

// File: rtl/dl_crc32_byte.sv
// dl_crc32_byte
// Purely combinational single-byte update of a reflected CRC-32 register.
// The byte is folded into the low bits and then eight LSB-first shift/XOR
// steps are applied, which is the textbook bitwise form of the algorithm.
// Ports:
//   crc_in   [31:0]  CRC register before this byte
//   byte_in  [7:0]   data byte
//   crc_out  [31:0]  CRC register after this byte

module dl_crc32_byte
    import dl_crc_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc_out
);

    // Unrolled eight-step reduction; each step shifts right and conditionally
    // XORs in the reflected polynomial when the bit shifted out was set.
    always_comb begin
        logic [31:0] acc;
        acc = crc_in ^ {24'h0, byte_in};
        for (int i = 0; i < 8; i++) begin
            if (acc[0]) begin
                acc = (acc >> 1) ^ CRC32_POLY_REFL;
            end else begin
                acc = acc >> 1;
            end
        end
        crc_out = acc;
    end

endmodule

// File: rtl/dl_crc32.sv
// dl_crc32
// Streaming CRC-32 accumulator (IEEE 802.3, reflected). Accepts framed beats
// over valid/ready, and on the last beat of a frame publishes the final CRC
// and holds it until the consumer takes it.
// Optional feature macro: DL_CRC32_BYTE_COUNT_EN adds out_len, the byte count
// of the completed frame (saturating at 16'hFFFF).
// Parameters:
//   DATA_W  beat width, 8/16/32
//   INIT    CRC register value at frame start
//   XOROUT  value XORed onto the final register to form out_crc
// Ports:
//   clk        clock, all state on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   beat valid
//   in_ready   block can accept a beat (depends on state only)
//   in_data    beat data, byte 0 = bits [7:0], processed first
//   in_last    final beat of the frame, qualified by in_valid
//   out_valid  out_crc holds a finished frame CRC
//   out_ready  consumer accepts out_crc
//   out_crc    final CRC of the last completed frame
//   out_len    (macro only) bytes in the completed frame

module dl_crc32
    import dl_crc_pkg::*;
#(
    parameter int          DATA_W = 8,
    parameter logic [31:0] INIT   = CRC32_INIT,
    parameter logic [31:0] XOROUT = CRC32_XOROUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_crc
`ifdef DL_CRC32_BYTE_COUNT_EN
    ,
    output logic [15:0]       out_len
`endif
);

    localparam int NBYTES = DATA_W / 8;

    crc_state_e  state_q;
    crc_state_e  state_d;
    logic [31:0] crc_q;
    logic        accept;
    logic [31:0] chain [0:NBYTES];

    // Byte lanes are folded in order, lane 0 first, by chaining one
    // combinational byte stage per lane.
    assign chain[0] = crc_q;

    for (genvar g = 0; g < NBYTES; g++) begin : g_lane
        dl_crc32_byte u_byte (
            .crc_in  (chain[g]),
            .byte_in (in_data[8*g +: 8]),
            .crc_out (chain[g+1])
        );
    end

    // Handshake outputs come straight from the state so no input ever
    // reaches an output combinationally; next state follows the handshakes.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    assign accept = in_valid & in_ready;

    // State and CRC datapath. The running register is re-armed to INIT on
    // the last beat so the next frame starts clean, while out_crc keeps the
    // finished value until another frame completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            crc_q   <= INIT;
            out_crc <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (in_last) begin
                    out_crc <= chain[NBYTES] ^ XOROUT;
                    crc_q   <= INIT;
                end else begin
                    crc_q   <= chain[NBYTES];
                end
            end
        end
    end

`ifdef DL_CRC32_BYTE_COUNT_EN
    logic [15:0] len_q;
    logic [16:0] len_sum;
    logic [15:0] len_next;

    // Saturating byte count for the frame in progress.
    always_comb begin
        len_sum  = {1'b0, len_q} + 17'(NBYTES);
        len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    end

    // The in-progress count is cleared when a frame finishes so the next
    // frame starts from zero; the finished count is held alongside out_crc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q   <= '0;
            out_len <= '0;
        end else if (accept) begin
            if (in_last) begin
                out_len <= len_next;
                len_q   <= '0;
            end else begin
                len_q   <= len_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dl_crc32.sv
// tb_dl_crc32
// Directed bench for dl_crc32: an 8-bit instance driven from a vector table
// plus hand-written sequences (backpressure, mid-frame reset, valid gaps),
// and a 32-bit instance for word-wide frames. Expected CRCs are the standard
// CRC-32 values of the given byte strings.

module tb_dl_crc32;

    logic        clk;
    logic        rst_n;
    logic        out_ready;

    logic        in8_valid;
    logic        in8_ready;
    logic [7:0]  in8_data;
    logic        in8_last;
    logic        out8_valid;
    logic [31:0] out8_crc;

    logic        in32_valid;
    logic        in32_ready;
    logic [31:0] in32_data;
    logic        in32_last;
    logic        out32_valid;
    logic [31:0] out32_crc;

`ifdef DL_CRC32_BYTE_COUNT_EN
    logic [15:0] out8_len;
    logic [15:0] out32_len;
`endif

    int tests    = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic [31:0] exp_crc;
        logic [15:0] exp_len;
    } vec_t;

    vec_t tbl [0:10];

    dl_crc32 #(.DATA_W(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in8_valid),
        .in_ready  (in8_ready),
        .in_data   (in8_data),
        .in_last   (in8_last),
        .out_valid (out8_valid),
        .out_ready (out_ready),
        .out_crc   (out8_crc)
`ifdef DL_CRC32_BYTE_COUNT_EN
        ,
        .out_len   (out8_len)
`endif
    );

    dl_crc32 #(.DATA_W(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in32_valid),
        .in_ready  (in32_ready),
        .in_data   (in32_data),
        .in_last   (in32_last),
        .out_valid (out32_valid),
        .out_ready (out_ready),
        .out_crc   (out32_crc)
`ifdef DL_CRC32_BYTE_COUNT_EN
        ,
        .out_len   (out32_len)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Offers one beat to the chosen instance, waits (bounded) for acceptance,
    // and returns #1 after the accepting edge with valid withdrawn.
    task automatic applyStimulus(input bit wide, input logic [31:0] data,
                                 input logic last);
        int waited;
        waited = 0;
        if (wide) begin
            in32_valid = 1'b1; in32_data = data; in32_last = last;
        end else begin
            in8_valid = 1'b1; in8_data = data[7:0]; in8_last = last;
        end
        while (!(wide ? in32_ready : in8_ready) && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 20) begin
            tests++;
            failures++;
            $display("[TB] FAIL accept_timeout: in_ready got 0, expected 1");
        end else begin
            @(posedge clk); #1;
        end
        in8_valid  = 1'b0; in8_last  = 1'b0;
        in32_valid = 1'b0; in32_last = 1'b0;
    endtask

    task automatic checkResult8(input string name, input logic [31:0] crc,
                                input logic [15:0] len);
        checkOutput({name, "_valid"}, {31'h0, out8_valid}, 32'h1);
        checkOutput({name, "_crc"}, out8_crc, crc);
`ifdef DL_CRC32_BYTE_COUNT_EN
        checkOutput({name, "_len"}, {16'h0, out8_len}, {16'h0, len});
`else
        if (len == 16'hFFFF) $display("[TB] unexpected length marker");
`endif
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1;
        in8_valid = 0; in8_data = '0; in8_last = 0;
        in32_valid = 0; in32_data = '0; in32_last = 0;

        // "123456789", then "a", then a single zero byte.
        for (int i = 0; i < 9; i++) begin
            tbl[i] = '{8'h31 + 8'(i), (i == 8), 32'hCBF4_3926, 16'd9};
        end
        tbl[9]  = '{8'h61, 1'b1, 32'hE8B7_BE43, 16'd1};
        tbl[10] = '{8'h00, 1'b1, 32'hD202_EF8D, 16'd1};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("reset_out_valid", {31'h0, out8_valid}, 32'h0);
        checkOutput("reset_out_crc", out8_crc, 32'h0);
        checkOutput("reset_in_ready", {31'h0, in8_ready}, 32'h1);

        // Table-driven frames with out_ready held high.
        for (int i = 0; i <= 10; i++) begin
            applyStimulus(1'b0, {24'h0, tbl[i].data}, tbl[i].last);
            if (tbl[i].last) begin
                checkResult8($sformatf("vec%0d", i), tbl[i].exp_crc, tbl[i].exp_len);
            end
        end

        // Backpressure: result is held and an offered beat is refused.
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(1'b0, 32'h61, 1'b1);
        checkResult8("bp_first", 32'hE8B7_BE43, 16'd1);
        in8_valid = 1'b1; in8_data = 8'h31; in8_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("bp_hold%0d_valid", c), {31'h0, out8_valid}, 32'h1);
            checkOutput($sformatf("bp_hold%0d_crc", c), out8_crc, 32'hE8B7_BE43);
            checkOutput($sformatf("bp_hold%0d_ready", c), {31'h0, in8_ready}, 32'h0);
        end
        in8_valid = 1'b0; in8_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_valid", {31'h0, out8_valid}, 32'h0);
        checkOutput("bp_release_ready", {31'h0, in8_ready}, 32'h1);
        applyStimulus(1'b0, 32'h61, 1'b1);
        checkResult8("bp_next", 32'hE8B7_BE43, 16'd1);

        // Reset part-way through "12345", then a clean "123456789".
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h31 + i, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("midrst_out_valid", {31'h0, out8_valid}, 32'h0);
        checkOutput("midrst_out_crc", out8_crc, 32'h0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 32'h31 + i, (i == 8));
        checkResult8("midrst_frame", 32'hCBF4_3926, 16'd9);

        // Idle gaps with a stray in_last while in_valid is low.
        for (int i = 0; i < 9; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                in8_valid = 1'b0; in8_last = 1'b1; in8_data = 8'($urandom);
                @(posedge clk); #1;
            end
            applyStimulus(1'b0, 32'h31 + i, (i == 8));
        end
        checkResult8("gaps_frame", 32'hCBF4_3926, 16'd9);

        // Word-wide instance: "abcd" then four zero bytes.
        applyStimulus(1'b1, 32'h6463_6261, 1'b1);
        checkOutput("w32_abcd_valid", {31'h0, out32_valid}, 32'h1);
        checkOutput("w32_abcd_crc", out32_crc, 32'hED82_CD11);
`ifdef DL_CRC32_BYTE_COUNT_EN
        checkOutput("w32_abcd_len", {16'h0, out32_len}, 32'd4);
`endif
        applyStimulus(1'b1, 32'h0000_0000, 1'b1);
        checkOutput("w32_zero_crc", out32_crc, 32'h2144_DF1C);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
